// File: rtl/trade_history_buffer_pkg.sv
// Shared types and helpers for the trade history buffer and its min/max scanner.
package trade_hist_pkg;

    localparam int PRICE_W       = 8;
    localparam int DEPTH_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        PUBLISH = 2'd2
    } scan_state_t;

    // Logical index 0 is the oldest trade; once the ring has wrapped, the oldest sits at wr_ptr.
    function automatic logic [31:0] log_to_phys(
        input logic [31:0] idx,
        input logic [31:0] wr_ptr,
        input logic [31:0] count,
        input logic [31:0] depth
    );
        if (count < depth) begin
            return idx;
        end
        return (wr_ptr + idx) & (depth - 32'd1);
    endfunction

endpackage

// File: rtl/trade_history_buffer_if.sv
// Bus between matching engine / trend plotter and the trade history buffer.
interface trade_history_buffer_if
    import trade_hist_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic               match_signal;
    logic [PRICE_W-1:0] trade_price;
    logic [IDX_W-1:0]   rd_idx;
    logic [PRICE_W-1:0] rd_data;
    logic               rd_valid;
    logic [CNT_W-1:0]   count;
    logic               new_trade;
    logic [PRICE_W-1:0] hist_min;
    logic [PRICE_W-1:0] hist_max;
    logic               stats_valid;

    modport master (
        output match_signal, trade_price, rd_idx,
        input  rd_data, rd_valid, count, new_trade, hist_min, hist_max, stats_valid
    );

    modport slave (
        input  match_signal, trade_price, rd_idx,
        output rd_data, rd_valid, count, new_trade, hist_min, hist_max, stats_valid
    );

endinterface

// File: rtl/trade_history_buffer_scan.sv
// Background min/max scan over the stored window; restarts whenever trades arrive mid-scan.
//
// state   | meaning
// IDLE    | window unchanged since last publish, waiting for a write
// SCAN    | walking logical entries 0..count-1, accumulating tmin/tmax
// PUBLISH | copying tmin/tmax to outputs; rescan at once if a write arrived meanwhile
module hist_minmax_scan
    import trade_hist_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH):0]     count,
    input  logic [$clog2(DEPTH)-1:0]   wr_ptr,
    input  logic [PRICE_W-1:0]         scan_data,
    output logic [$clog2(DEPTH)-1:0]   scan_addr,
    output logic [PRICE_W-1:0]         hist_min,
    output logic [PRICE_W-1:0]         hist_max,
    output logic                       stats_valid
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    scan_state_t        state, state_nxt;
    logic [IDX_W-1:0]   i_q, i_nxt;
    logic [PRICE_W-1:0] tmin, tmin_nxt;
    logic [PRICE_W-1:0] tmax, tmax_nxt;
    logic               pending, pending_nxt;
    logic [PRICE_W-1:0] hist_min_nxt, hist_max_nxt;
    logic               stats_valid_nxt;
    logic               last_entry;

    assign scan_addr  = IDX_W'(log_to_phys(32'(i_q), 32'(wr_ptr), 32'(count), 32'(DEPTH)));
    assign last_entry = ({1'b0, i_q} >= (count - CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            i_q         <= '0;
            tmin        <= '0;
            tmax        <= '0;
            pending     <= 1'b0;
            hist_min    <= '0;
            hist_max    <= '0;
            stats_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            i_q         <= i_nxt;
            tmin        <= tmin_nxt;
            tmax        <= tmax_nxt;
            pending     <= pending_nxt;
            hist_min    <= hist_min_nxt;
            hist_max    <= hist_max_nxt;
            stats_valid <= stats_valid_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        i_nxt           = i_q;
        tmin_nxt        = tmin;
        tmax_nxt        = tmax;
        pending_nxt     = pending;
        hist_min_nxt    = hist_min;
        hist_max_nxt    = hist_max;
        stats_valid_nxt = stats_valid;
        case (state)
            IDLE: begin
                if (wr_en) begin
                    state_nxt = SCAN;
                    i_nxt     = '0;
                    tmin_nxt  = '1;
                    tmax_nxt  = '0;
                end
            end
            SCAN: begin
                if (wr_en) pending_nxt = 1'b1;
                if (scan_data < tmin) tmin_nxt = scan_data;
                if (scan_data > tmax) tmax_nxt = scan_data;
                if (last_entry) state_nxt = PUBLISH;
                else            i_nxt     = i_q + IDX_W'(1);
            end
            PUBLISH: begin
                hist_min_nxt    = tmin;
                hist_max_nxt    = tmax;
                stats_valid_nxt = 1'b1;
                // A write landing in this very cycle is consumed here rather than parked in pending.
                if (pending || wr_en) begin
                    pending_nxt = 1'b0;
                    state_nxt   = SCAN;
                    i_nxt       = '0;
                    tmin_nxt    = '1;
                    tmax_nxt    = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/trade_history_buffer.sv
// Circular trade-price history with an oldest-first registered read port and min/max stats.
module trade_history_buffer
    import trade_hist_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
)(
    input  logic                  clk,
    input  logic                  reset,
    trade_history_buffer_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [PRICE_W-1:0] mem [DEPTH];
    logic               match_prev;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count_q;
    logic [IDX_W-1:0]   rd_phys;
    logic               rd_in_range;
    logic [PRICE_W-1:0] rd_data_q;
    logic               rd_valid_q;
    logic               new_trade_q;
    logic [IDX_W-1:0]   scan_addr;
    logic [PRICE_W-1:0] scan_data;
    logic [PRICE_W-1:0] hist_min, hist_max;
    logic               stats_valid;

    assign wr_en       = bus.match_signal & ~match_prev;
    assign rd_in_range = ({1'b0, bus.rd_idx} < count_q);
    assign rd_phys     = IDX_W'(log_to_phys(32'(bus.rd_idx), 32'(wr_ptr), 32'(count_q), 32'(DEPTH)));
    assign scan_data   = mem[scan_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            match_prev  <= 1'b0;
            wr_ptr      <= '0;
            count_q     <= '0;
            new_trade_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            match_prev  <= bus.match_signal;
            new_trade_q <= wr_en;
            rd_valid_q  <= rd_in_range;
            rd_data_q   <= rd_in_range ? mem[rd_phys] : '0;
            if (wr_en) begin
                wr_ptr <= wr_ptr + IDX_W'(1);
                if (count_q != CNT_W'(DEPTH)) count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // Storage is deliberately not cleared; count=0 makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) mem[wr_ptr] <= bus.trade_price;
    end

    hist_minmax_scan #(.DEPTH(DEPTH)) u_scan (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en && !reset),
        .count       (count_q),
        .wr_ptr      (wr_ptr),
        .scan_data   (scan_data),
        .scan_addr   (scan_addr),
        .hist_min    (hist_min),
        .hist_max    (hist_max),
        .stats_valid (stats_valid)
    );

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.count       = count_q;
    assign bus.new_trade   = new_trade_q;
    assign bus.hist_min    = hist_min;
    assign bus.hist_max    = hist_max;
    assign bus.stats_valid = stats_valid;

endmodule

// File: tb/tb_trade_history_buffer.sv
// Bench for trade_history_buffer: vector table, directed corner sequences, random traffic vs queue model.
module tb_trade_history_buffer;
    import trade_hist_pkg::*;

    localparam int DEPTH = DEPTH_DEFAULT;
    localparam int IDX_W = $clog2(DEPTH);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    trade_history_buffer_if #(.DEPTH(DEPTH)) bus ();
    trade_history_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        bit m; int p; int idx;
        int v; int d; int c; int n; int sv; int mn; int mx;
    } vec_t;

    int q[$];
    bit m_prev;
    int exp_valid, exp_data, exp_new;
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int q_min();
        int r = 255;
        foreach (q[k]) if (q[k] < r) r = q[k];
        return r;
    endfunction

    function automatic int q_max();
        int r = 0;
        foreach (q[k]) if (q[k] > r) r = q[k];
        return r;
    endfunction

    // Drive one cycle from a negedge; model sees the pre-write window for the read.
    task automatic cycle(input bit m, input int p, input int idx);
        bus.match_signal = m;
        bus.trade_price  = PRICE_W'(p);
        bus.rd_idx       = IDX_W'(idx);
        @(posedge clk);
        exp_valid = (idx < q.size()) ? 1 : 0;
        exp_data  = (exp_valid != 0) ? q[idx] : 0;
        exp_new   = (m && !m_prev) ? 1 : 0;
        m_prev    = m;
        if (exp_new != 0) begin
            q.push_back(p);
            if (q.size() > DEPTH) void'(q.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic check_cycle(input string tag);
        check({tag, " rd_valid"},  32'(bus.rd_valid),  exp_valid);
        check({tag, " rd_data"},   32'(bus.rd_data),   exp_data);
        check({tag, " count"},     32'(bus.count),     q.size());
        check({tag, " new_trade"}, 32'(bus.new_trade), exp_new);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.match_signal = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        q.delete();
        m_prev = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want finish before 500000");
        $fatal(1, "watchdog");
    end

    vec_t tbl[14];
    int pulses;

    initial begin
        bus.match_signal = 1'b0;
        bus.trade_price  = '0;
        bus.rd_idx       = '0;
        do_reset();

        check("reset rd_valid",    32'(bus.rd_valid),    0);
        check("reset rd_data",     32'(bus.rd_data),     0);
        check("reset count",       32'(bus.count),       0);
        check("reset new_trade",   32'(bus.new_trade),   0);
        check("reset stats_valid", 32'(bus.stats_valid), 0);
        check("reset hist_min",    32'(bus.hist_min),    0);
        check("reset hist_max",    32'(bus.hist_max),    0);

        // Trades 50, 30, 70 (1 high, 3 low); last write at row 9, stats 30/70 appear at row 13 (E+5).
        //            m  p   idx v  d   c  n  sv mn  mx
        tbl[0]  = '{0, 0,  0, 0, 0,  0, 0, 0, 0,  0};
        tbl[1]  = '{1, 50, 0, 0, 0,  1, 1, 0, 0,  0};
        tbl[2]  = '{0, 0,  0, 1, 50, 1, 0, 0, 0,  0};
        tbl[3]  = '{0, 0,  1, 0, 0,  1, 0, 1, 50, 50};
        tbl[4]  = '{0, 0,  0, 1, 50, 1, 0, 1, 50, 50};
        tbl[5]  = '{1, 30, 1, 0, 0,  2, 1, 1, 50, 50};
        tbl[6]  = '{0, 0,  1, 1, 30, 2, 0, 1, 50, 50};
        tbl[7]  = '{0, 0,  2, 0, 0,  2, 0, 1, 50, 50};
        tbl[8]  = '{0, 0,  0, 1, 50, 2, 0, 1, 30, 50};
        tbl[9]  = '{1, 70, 2, 0, 0,  3, 1, 1, 30, 50};
        tbl[10] = '{0, 0,  2, 1, 70, 3, 0, 1, 30, 50};
        tbl[11] = '{0, 0,  1, 1, 30, 3, 0, 1, 30, 50};
        tbl[12] = '{0, 0,  0, 1, 50, 3, 0, 1, 30, 50};
        tbl[13] = '{0, 0,  3, 0, 0,  3, 0, 1, 30, 70};
        for (int r = 0; r < 14; r++) begin
            cycle(tbl[r].m, tbl[r].p, tbl[r].idx);
            check($sformatf("tbl%0d rd_valid", r),    32'(bus.rd_valid),    tbl[r].v);
            check($sformatf("tbl%0d rd_data", r),     32'(bus.rd_data),     tbl[r].d);
            check($sformatf("tbl%0d count", r),       32'(bus.count),       tbl[r].c);
            check($sformatf("tbl%0d new_trade", r),   32'(bus.new_trade),   tbl[r].n);
            check($sformatf("tbl%0d stats_valid", r), 32'(bus.stats_valid), tbl[r].sv);
            check($sformatf("tbl%0d hist_min", r),    32'(bus.hist_min),    tbl[r].mn);
            check($sformatf("tbl%0d hist_max", r),    32'(bus.hist_max),    tbl[r].mx);
        end

        // Level held high for 20 cycles is a single trade.
        do_reset();
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1, 99, 0);
            if (bus.new_trade === 1'b1) pulses++;
            check_cycle("hold");
        end
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0);
            if (bus.new_trade === 1'b1) pulses++;
            check_cycle("hold tail");
        end
        check("hold pulses", 32'(pulses), 1);
        check("hold count", 32'(bus.count), 1);
        check("hold rd_data", 32'(bus.rd_data), 99);

        // Wrap-around: 70 trades of 1..70 into 64 entries.
        do_reset();
        for (int k = 1; k <= 70; k++) begin
            cycle(1, k, $urandom_range(0, DEPTH - 1));
            check_cycle("wrap wr");
            cycle(0, 0, $urandom_range(0, DEPTH - 1));
            check_cycle("wrap gap");
        end
        cycle(0, 0, 0);
        check("wrap idx0", 32'(bus.rd_data), 7);
        cycle(0, 0, 63);
        check("wrap idx63", 32'(bus.rd_data), 70);
        check("wrap count", 32'(bus.count), 64);
        repeat (150) cycle(0, 0, 0);
        check("wrap hist_min", 32'(bus.hist_min), 7);
        check("wrap hist_max", 32'(bus.hist_max), 70);
        check("wrap stats_valid", 32'(bus.stats_valid), 1);

        // Write of 5 in the middle of a full-window scan of 100s.
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            cycle(1, 100, 0);
            cycle(0, 0, 0);
        end
        repeat (100) cycle(0, 0, 0);
        check("mid pre hist_min", 32'(bus.hist_min), 100);
        cycle(1, 100, 0);
        repeat (10) cycle(0, 0, 0);
        check("mid scanning", 32'(dut.u_scan.state), 32'(SCAN));
        cycle(1, 5, 63);
        check_cycle("mid wr");
        cycle(0, 0, 63);
        check("mid landed", 32'(bus.rd_data), 5);
        check("mid count", 32'(bus.count), 64);
        for (int k = 0; k < 200; k++) begin
            cycle(0, 0, k % DEPTH);
            check_cycle("mid drain");
        end
        check("mid hist_min", 32'(bus.hist_min), 5);
        check("mid hist_max", 32'(bus.hist_max), 100);

        // Reset during a scan.
        cycle(1, 42, 0);
        repeat (3) cycle(0, 0, 0);
        check("rs in scan", 32'(dut.u_scan.state), 32'(SCAN));
        reset = 1'b1;
        bus.match_signal = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rs state", 32'(dut.u_scan.state), 32'(IDLE));
        check("rs count", 32'(bus.count), 0);
        check("rs stats_valid", 32'(bus.stats_valid), 0);
        check("rs hist_min", 32'(bus.hist_min), 0);
        check("rs hist_max", 32'(bus.hist_max), 0);
        check("rs rd_valid", 32'(bus.rd_valid), 0);
        check("rs new_trade", 32'(bus.new_trade), 0);
        reset = 1'b0;
        q.delete();
        m_prev = 1'b0;
        repeat (100) cycle(0, 0, 0);
        check("rs no publish", 32'(bus.stats_valid), 0);

        // Random traffic against the queue model.
        for (int rnd = 0; rnd < 4; rnd++) begin
            for (int k = 0; k < 150; k++) begin
                cycle($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, DEPTH - 1));
                check_cycle("rnd");
            end
            for (int k = 0; k < 150; k++) begin
                cycle(0, 0, $urandom_range(0, DEPTH - 1));
                check_cycle("rnd idle");
            end
            if (q.size() > 0) begin
                check("rnd hist_min", 32'(bus.hist_min), q_min());
                check("rnd hist_max", 32'(bus.hist_max), q_max());
                check("rnd stats_valid", 32'(bus.stats_valid), 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/trade_history_buffer.md
# trade_history_buffer

Circular history of executed trade prices, sitting between the matching engine and the VGA trend display. It captures one entry per rising edge of `match_signal`, keeps the last `DEPTH` trades, and serves them oldest-first through a registered random-read port that the trend plotter indexes by screen column. A background scan publishes the minimum and maximum of the stored window, so the display can auto-scale its vertical axis.

## Interface
- `DEPTH`, 64: number of stored trades; must be a power of two, ≥ 2.
- `PRICE_W`, 8: width of the trade price.
- `clk`  in  1  system clock (CLOCK_50 domain); one clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `match_signal`  in  1  level from the matching engine; each 0→1 transition is one trade.
- `trade_price`  in  PRICE_W  price of the trade; sampled in the edge cycle.
- `rd_idx`  in  log2(DEPTH)  logical read index; 0 = oldest stored trade.
- `rd_data`  out  PRICE_W  price at `rd_idx`, registered.
- `rd_valid`  out  1  registered; 1 iff the sampled `rd_idx` < `count`.
- `count`  out  log2(DEPTH)+1  number of stored trades, saturating at `DEPTH`.
- `new_trade`  out  1  one-cycle pulse, high in the cycle after a write.
- `hist_min`, `hist_max`  out  PRICE_W  min/max of the stored window.
- `stats_valid`  out  1  high once the first scan has published.

## Operation
- Edge detect: register `match_prev`. A write occurs in cycle E when `match_signal`=1 and `match_prev`=0. If `match_signal` is held high, only one write occurs. `match_prev` resets to 0, so a level already high when reset releases counts as an edge.
- Write: `mem[wr_ptr] <= trade_price`, `wr_ptr <= wr_ptr+1` mod DEPTH, `count <= min(count+1, DEPTH)`.
- When full, the next write overwrites the oldest entry.
- Logical-to-physical read mapping:
  - physical = `rd_idx` when `count` < DEPTH;
  - physical = (`wr_ptr` + `rd_idx`) mod DEPTH when full.
- Reads for out-of-range indices (`rd_idx` ≥ `count`) drive `rd_valid`=0 and `rd_data`=0.
- Scan FSM has states IDLE, SCAN, PUBLISH.
  - IDLE→SCAN on a write; i=0, tmin=all-ones, tmax=0.
  - SCAN reads one logical entry per cycle, updating tmin/tmax. After i=`count`−1 it goes to PUBLISH.
  - PUBLISH drives `hist_min<=tmin`, `hist_max<=tmax`, `stats_valid<=1`, then returns to IDLE. If the pending flag is set, it instead clears the flag and goes directly to SCAN with i=0.
- A write during SCAN or PUBLISH sets `pending`. The write itself is never delayed or dropped.
- The scan uses the `count`/`wr_ptr` values current in each cycle.
- `hist_min`/`hist_max` hold their previous values during a scan. `stats_valid` stays 1 until reset.
- Reset, including mid-scan:
  - `wr_ptr`, `count`, `match_prev`, `pending` = 0;
  - FSM = IDLE;
  - all outputs = 0;
  - memory contents are not cleared (unreachable because `count`=0).

## Timing
- Write cycle E → `count`, `new_trade`=1 and the updated mapping are visible at E+1.
- Read latency is 1 cycle: `rd_idx` sampled at cycle R → `rd_data`/`rd_valid` at R+1.
- A read and a write in the same cycle: the read uses the pre-write `wr_ptr`/`count`/memory.
- Stats latency for a single isolated write at E:
  - SCAN covers E+1 … E+`count`;
  - PUBLISH is at E+`count`+1;
  - new `hist_min`/`hist_max` are visible at E+`count`+2.
- Back-to-back edges need ≥ 1 low cycle of `match_signal` between them. The maximum write rate is therefore one per 2 cycles, and every such write is captured.

## Structure
- Shared package `trade_hist_pkg` holds:
  - `PRICE_W`;
  - the default `DEPTH`;
  - the scan-state enum (IDLE, SCAN, PUBLISH);
  - the logical-to-physical index function.
- Sub-module `hist_minmax_scan` contains the FSM, the pending flag and the tmin/tmax accumulators. It drives a second combinational read index into the storage array.
- Top-level logic: edge detect, write pointer, `count`, storage array, registered read port.

## Test plan
- Reset, then read `rd_idx`=0 → `rd_valid`=0, `rd_data`=0, `count`=0, `stats_valid`=0, all outputs 0.
- Three trades with prices 50, 30, 70 (`match_signal` high 1 cycle, low 3 cycles each):
  - `count`=3;
  - reads at idx 0/1/2 return 50/30/70;
  - `hist_min`=30, `hist_max`=70, `stats_valid`=1;
  - after the last write at E, the values appear exactly at E+5.
- `match_signal` held high for 20 cycles with `trade_price`=99 → exactly one write, `count`=1, one `new_trade` pulse.
- DEPTH=64 with 70 trades of prices 1…70:
  - `count`=64;
  - idx 0 → 7, idx 63 → 70;
  - `hist_min`=7, `hist_max`=70.
- A trade with price 5 arriving mid-scan of a full buffer (all 100):
  - the write lands immediately;
  - the first publish may show min=100;
  - the pending rescan then publishes `hist_min`=5;
  - no write is lost.
- Reset asserted during SCAN → next cycle FSM is IDLE, `count`=0, `stats_valid`=0, `hist_min`=`hist_max`=0.
